// File: rtl/cos_fix2float_pkg.sv
// Shared constants and state encoding for the fixed-to-float converter that sits behind the CORDIC cosine stage.
package cos_fix2float_pkg;

  localparam int FIX_WIDTH     = 22;
  localparam int FIX_FRAC_BITS = 20;
  localparam int EXP_BIAS      = 127;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FLT_W  = SIGN_W + EXP_W + MANT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_PACK
  } state_t;

endpackage

// File: rtl/cos_fix2float.sv
// Signed Q1.20 to IEEE-754 single conversion by iterative left-normalisation; done rises 3+s edges
// after the accepting edge (2 for zero); clk_en is only looked at in IDLE, so busy acts as the stall.
module cos_fix2float
  import cos_fix2float_pkg::*;
#(
  parameter int WIDTH     = FIX_WIDTH,
  parameter int FRAC_BITS = FIX_FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] fix_in,
  output logic [FLT_W-1:0] float_out,
  output logic             done,
  output logic             busy
);

  localparam int S_W = $clog2(WIDTH);
  // A magnitude with its top bit set is worth 2^(WIDTH-1-FRAC_BITS); each shift halves that.
  localparam int EXP_TOP = EXP_BIAS + WIDTH - 1 - FRAC_BITS;
  localparam int PAD_W   = MANT_W - (WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   fix_q;
  logic [WIDTH-1:0]   mag;
  logic [S_W-1:0]     s;
  logic               sign;
  logic               zero;
  logic [EXP_W-1:0]   expo;
  logic [MANT_W-1:0]  mant;

  assign expo = EXP_W'(EXP_TOP) - EXP_W'(s);
  // Leading one is implicit; the remaining magnitude bits fit the mantissa exactly, no rounding.
  assign mant = {mag[WIDTH-2:0], {PAD_W{1'b0}}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      fix_q     <= '0;
      mag       <= '0;
      s         <= '0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      float_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clk_en) begin
            fix_q <= fix_in;
            busy  <= 1'b1;
            state <= ST_ABS;
          end
        end
        ST_ABS: begin
          sign  <= fix_q[WIDTH-1];
          mag   <= fix_q[WIDTH-1] ? -fix_q : fix_q;
          s     <= '0;
          zero  <= (fix_q == '0);
          state <= (fix_q == '0) ? ST_PACK : ST_NORM;
        end
        ST_NORM: begin
          if (mag[WIDTH-1]) begin
            state <= ST_PACK;
          end else begin
            mag <= {mag[WIDTH-2:0], 1'b0};
            s   <= s + 1'b1;
          end
        end
        ST_PACK: begin
          float_out <= zero ? '0 : {sign, expo, mant};
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cos_fix2float.sv
// Directed bench for cos_fix2float: hand-computed float encodings and done-edge positions.
module tb_cos_fix2float;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic [21:0] fix_in;
  logic [31:0] float_out;
  logic        done;
  logic        busy;

  int compared;
  int mismatched;

  cos_fix2float dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .fix_in    (fix_in),
    .float_out (float_out),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start for one edge (edge 0); returns #1 after that edge.
  task automatic start(input logic [21:0] v);
    @(negedge clk);
    clk_en = 1'b1;
    fix_in = v;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  // Edge index (relative to edge 0) at which done is seen high, or -1 on timeout.
  task automatic wait_done(input int max_edges, output int e);
    e = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        e = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    clk_en = 1'b0;
    fix_in = 22'h0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (float_out !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_float_out: got %h want %h", float_out, 32'h0);
    end
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_convert();
    logic [21:0] vin  [9] = '{22'h100000, 22'h300000, 22'h080000, 22'h200000, 22'h000001,
                              22'h000000, 22'h3FFFFF, 22'h1FFFFF, 22'h0C0000};
    logic [31:0] vout [9] = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'hC0000000, 32'h35800000,
                              32'h00000000, 32'hB5800000, 32'h3FFFFFF8, 32'h3F400000};
    int          vedge[9] = '{4, 4, 5, 3, 24, 2, 24, 4, 5};
    logic [31:0] prev;
    int          e;
    prev = 32'h0;
    for (int k = 0; k < 9; k++) begin
      start(vin[k]);
      compared++;
      if (busy !== 1'b1) begin
        mismatched++;
        $display("FAIL conv%0d_busy_after_accept: got %b want 1", k, busy);
      end
      compared++;
      if (float_out !== prev) begin
        mismatched++;
        $display("FAIL conv%0d_hold: got %h want %h", k, float_out, prev);
      end
      wait_done(40, e);
      compared++;
      if (e !== vedge[k]) begin
        mismatched++;
        $display("FAIL conv%0d_done_edge: got %0d want %0d", k, e, vedge[k]);
      end
      compared++;
      if (float_out !== vout[k]) begin
        mismatched++;
        $display("FAIL conv%0d_value in=%h: got %h want %h", k, vin[k], float_out, vout[k]);
      end
      compared++;
      if (busy !== 1'b0) begin
        mismatched++;
        $display("FAIL conv%0d_busy_at_done: got %b want 0", k, busy);
      end
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b0) begin
        mismatched++;
        $display("FAIL conv%0d_done_pulse: got %b want 0", k, done);
      end
      prev = vout[k];
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] vin  [3] = '{22'h000000, 22'h100000, 22'h080000};
    logic [31:0] vout [3] = '{32'h00000000, 32'h3F800000, 32'h3F000000};
    int          vedge[3] = '{2, 7, 13};
    int          ndone;
    ndone = 0;
    @(negedge clk);
    clk_en = 1'b1;
    fix_in = vin[0];
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (ndone < 3) begin
          compared++;
          if (float_out !== vout[ndone]) begin
            mismatched++;
            $display("FAIL b2b%0d_value: got %h want %h", ndone, float_out, vout[ndone]);
          end
          compared++;
          if (e !== vedge[ndone]) begin
            mismatched++;
            $display("FAIL b2b%0d_edge: got %0d want %0d", ndone, e, vedge[ndone]);
          end
        end
        ndone++;
        if (ndone < 3) fix_in = vin[ndone];
        else clk_en = 1'b0;
      end
    end
    clk_en = 1'b0;
    compared++;
    if (ndone !== 3) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want 3", ndone);
    end
  endtask

  task automatic test_reset_abort();
    int e;
    start(22'h000001);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    compared++;
    if (float_out !== 32'h0) begin
      mismatched++;
      $display("FAIL abort_float_out: got %h want %h", float_out, 32'h0);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_done: got %b want 0", done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wait_done(30, e);
    compared++;
    if (e !== -1) begin
      mismatched++;
      $display("FAIL abort_no_done: got done at edge %0d want none", e);
    end
    start(22'h100000);
    wait_done(40, e);
    compared++;
    if (e !== 4) begin
      mismatched++;
      $display("FAIL after_abort_edge: got %0d want 4", e);
    end
    compared++;
    if (float_out !== 32'h3F800000) begin
      mismatched++;
      $display("FAIL after_abort_value: got %h want %h", float_out, 32'h3F800000);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cos_fix2float.md
COS_FIX2FLOAT -- requirements
Module: cos_fix2float

Interface
REQ-001 SHALL have parameter WIDTH, default 22: width of the fixed-point input.
REQ-002 SHALL have parameter FRAC_BITS, default 20: fraction bits of the input (signed Q1.20).
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clk_en, input, 1: start strobe; it is sampled only in IDLE.
REQ-006 SHALL have port fix_in, input, WIDTH: two's-complement cosine value from the CORDIC stage, captured on accepted start.
REQ-007 SHALL have port float_out, output, 32: IEEE-754 single-precision result, held until the next done.
REQ-008 SHALL have port done, output, 1: one-cycle pulse marking float_out valid.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-010 SHALL implement the states IDLE, ABS, NORM and PACK.
REQ-011 IDLE with clk_en=1 at an edge SHALL capture fix_in and go to ABS; clk_en in any other state SHALL be ignored.
REQ-012 ABS SHALL register sign = fix_in[WIDTH-1] and mag = |fix_in| as a WIDTH-bit unsigned value (0x200000 gives mag 2^21), clear the shift count s, then go to NORM, or to PACK with a zero flag if mag=0.
REQ-013 NORM SHALL go to PACK if mag[WIDTH-1]=1; otherwise it SHALL shift mag left by one and increment s (5-bit counter, max 21).
REQ-014 PACK SHALL register float_out = {sign, exp, mant}, where exp = 128 - s (8 bits) and mant = {mag[WIDTH-2:0], 2'b00}.
REQ-015 The conversion SHALL be exact; rounding logic SHALL NOT be present.
REQ-016 If the zero flag is set, PACK SHALL output 0x00000000 (always +0).
REQ-017 PACK SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 Latency from the accepting edge to the edge that raises done SHALL be 3+s edges; for zero input it SHALL be 2 edges.
REQ-019 Worst-case latency SHALL be 24 edges (input 0x000001).
REQ-020 Back-to-back: clk_en asserted in the cycle done is high SHALL be accepted, since the state is then IDLE.
REQ-021 float_out SHALL change only at the done edge.
REQ-022 Subnormal, infinity and NaN outputs SHALL be unreachable for any WIDTH=22 input.

Reset
REQ-023 While reset=0: state=IDLE, float_out=0, done=0, busy=0, and mag, s, sign and the zero flag cleared, independent of clk.
REQ-024 Reset mid-conversion SHALL abort the conversion; no done SHALL follow.
REQ-025 The first clk_en after reset release SHALL be accepted normally.

Structure
REQ-026 A shared package SHALL hold WIDTH, FRAC_BITS, EXP_BIAS (127), the state enum, and the float field widths (1/8/23).
REQ-027 The block SHALL be a single module; the normalizer is iterative inside NORM, and no sub-module is required.
REQ-028 The block SHALL connect directly to the CORDIC cosine stage: its done drives clk_en here, its cos_out drives fix_in.

Verification
REQ-029 fix_in=0x100000 (1.0) -> float_out=0x3F800000; done at edge 4; s=1.
REQ-030 fix_in=0x300000 (-1.0) -> float_out=0xBF800000; fix_in=0x080000 (0.5) -> 0x3F000000 at edge 5.
REQ-031 fix_in=0x200000 (-2.0, s=0) -> float_out=0xC0000000 at edge 3; fix_in=0x000001 -> 0x35800000 at edge 24.
REQ-032 fix_in=0x000000 -> float_out=0x00000000; done at edge 2.
REQ-033 clk_en held high continuously -> conversions run back-to-back, one done per conversion, with no lost or duplicated result.
REQ-034 reset=0 asserted at edge 3 of a 0x000001 conversion -> outputs 0 immediately, no done; a following 0x100000 start yields 0x3F800000.
